pc_unit: RTL

//   Parametrised program-counter unit. Holds the current instruction address and

---
 rtl/pc_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address and picks the next one from
// reset, exception entry/return, stall, jump, branch or sequential step.
module pc_unit #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned STEP         = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic [WIDTH-1:0] epc,
    output logic             in_exc,
    output logic             exc_dropped,
    output logic             fetch_valid
);

    // STEP is a power of two, so STEP-1 covers exactly the bits to clear.
    localparam logic [WIDTH-1:0] AlignMask = ~(WIDTH'(STEP - 1));
    localparam logic [WIDTH-1:0] ResetPc   = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] ExcPc     = WIDTH'(EXC_VECTOR) & AlignMask;

    typedef enum logic [0:0] {StNormal, StInExc} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             dropped_q, dropped_d;
    logic             warm_q;
    logic             fetch_valid_q;

    assign pc_plus_step = pc_q + WIDTH'(STEP);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        dropped_d = dropped_q;

        if (exc_req && state_q == StNormal) begin
            epc_d   = pc_q;
            pc_d    = ExcPc;
            state_d = StInExc;
        end else begin
            // A second exception while in the handler is recorded, not nested.
            if (exc_req) begin
                dropped_d = 1'b1;
            end
            if (eret && state_q == StInExc) begin
                pc_d    = epc_q;
                state_d = StNormal;
            end else if (stall) begin
                pc_d = pc_q;
            end else if (jump) begin
                pc_d = jump_target & AlignMask;
            end else if (branch_taken) begin
                pc_d = branch_target & AlignMask;
            end else begin
                pc_d = pc_plus_step;
            end
        end
    end

    assign pc_next = rst ? ResetPc : pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StNormal;
            pc_q          <= ResetPc;
            epc_q         <= '0;
            dropped_q     <= 1'b0;
            warm_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            dropped_q     <= dropped_d;
            warm_q        <= 1'b1;
            fetch_valid_q <= warm_q;
        end
    end

    assign pc          = pc_q;
    assign epc         = epc_q;
    assign in_exc      = (state_q == StInExc);
    assign exc_dropped = dropped_q;
    assign fetch_valid = fetch_valid_q;

endmodule
